fetch_stage: RTL
================

# fetch_stage

Parametrised instruction-fetch stage: program counter, PC incrementer, redirect mux, synchronous instruction-memory request tracking and IF/ID pipeline register, all in one block. It adds stall, flush and branch redirect to the fetch path and widens it beyond 16 bits. It sits between the instruction memory and the decode stage. The hazard/branch unit drives its control inputs.

## Interface
- ADDR_W, 16, PC and address width
- INST_W, 16, instruction width
- PC_INC, 2, PC increment per fetch (bytes)
- RESET_PC, 0, PC value after reset
- NOP_INST, 0, instruction word loaded into IF/ID on reset or flush

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- stall_i  in  1  hold the PC, the in-flight request and IF/ID
- flush_i  in  1  kill the in-flight request and the IF/ID contents
- redirect_i  in  1  load the PC from redirect_pc_i; implies flush
- redirect_pc_i  in  ADDR_W  redirect target
- imem_addr_o  out  ADDR_W  instruction memory read address
- imem_data_i  in  INST_W  read data, valid one cycle after the address
- ifid_inst_o  out  INST_W  IF/ID instruction
- ifid_pc_o  out  ADDR_W  IF/ID PC+PC_INC of that instruction
- ifid_valid_o  out  1  IF/ID holds a live instruction

## Operation
- State registers:
  - pc_q: next address to issue.
  - rq_pc_q, rq_valid_q: request in flight.
  - IF/ID registers.
- Advance (no stall, flush or redirect):
  - imem_addr_o = pc_q.
  - pc_q <= pc_q+PC_INC.
  - rq_pc_q <= pc_q; rq_valid_q <= 1.
  - IF/ID <= {imem_data_i, rq_pc_q+PC_INC, rq_valid_q}.
- Stall:
  - imem_addr_o = rq_pc_q, which re-reads the same word.
  - pc_q, rq_* and IF/ID all hold.
- Flush:
  - rq_valid_q <= 0.
  - IF/ID <= {NOP_INST, 0, 0}.
  - pc_q advances normally.
- Redirect:
  - imem_addr_o = redirect_pc_i, so the target is issued the same cycle.
  - pc_q <= redirect_pc_i+PC_INC.
  - rq_pc_q <= redirect_pc_i; rq_valid_q <= 1.
  - IF/ID flushed as for flush.
- Priority: reset > redirect > flush > stall > advance. Flush or redirect during a stall wins over the stall.
- Arithmetic is modulo 2^ADDR_W. The PC wraps from 2^ADDR_W-PC_INC to 0 without any flag.

## Timing
- Reset values:
  - pc_q = RESET_PC, rq_pc_q = 0, rq_valid_q = 0.
  - ifid_inst_o = NOP_INST, ifid_pc_o = 0, ifid_valid_o = 0.
  - imem_addr_o = RESET_PC.
- After rst deasserts, the first valid IF/ID appears 2 cycles later (issue cycle, then capture cycle).
- Steady state delivers one instruction per cycle.
- Redirect in cycle t: IF/ID is invalid at t+1, and the target instruction is valid at t+2.
- Reset mid-operation clears all state immediately; there are no partial updates.
- stall_i held for N cycles delays the stream by exactly N cycles, with no loss or duplication.

## Configuration
- FETCH_STAT_EN defined:
  - Adds output fetch_cnt_o[31:0], which counts cycles in which IF/ID loads with valid=1.
  - The counter saturates at 2^32-1 and resets to 0.
- Not defined: the port and the counter logic are absent.

## Structure
- Shared package fetch_pkg holds the default widths, NOP_INST, RESET_PC and the IF/ID payload struct typedef.
- One sub-module, fetch_pc_gen, contains pc_q, the incrementer and the redirect/stall mux.
- IF/ID and request tracking stay in fetch_stage.

## Test plan
- Reset then run, with imem returning data=addr: IF/ID shows (inst 0x0000, pc 0x0002), then (0x0002, 0x0004), then (0x0004, 0x0006), one per cycle, valid from cycle 2.
- Stall 3 cycles mid-stream at inst 0x0006: IF/ID holds 0x0006 for 3 extra cycles, then 0x0008 follows with no gap or duplicate.
- Redirect to 0x0100 at cycle t: IF/ID is invalid with NOP_INST at t+1, and (0x0100, 0x0102) is valid at t+2.
- Flush together with stall: the flush wins, IF/ID is invalid next cycle, and the PC still advances.
- PC at 0xFFFE: the next issued address is 0x0000 and ifid_pc_o = 0x0000 for inst 0xFFFE.
- rst asserted asynchronously mid-stream: all outputs take their reset values before the next clock edge. With FETCH_STAT_EN defined, fetch_cnt_o = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: default widths, reset/NOP constants, fetch action encoding
// and the IF/ID payload type shared by the fetch stage and its consumers.
package fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_INST_W = 16;
    localparam int DEF_PC_INC = 2;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
    localparam logic [DEF_INST_W-1:0] DEF_NOP_INST = '0;

    // What the fetch path does this cycle, already resolved by priority.
    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_FLUSH,
        ACT_REDIRECT
    } fetch_act_t;

    // IF/ID payload at the default widths, as seen by the decode stage.
    typedef struct packed {
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_ADDR_W-1:0] pc;
        logic                  valid;
    } ifid_t;

    // Redirect beats flush, flush beats stall, otherwise the stream advances.
    function automatic fetch_act_t decode_act(input logic redirect,
                                              input logic flush,
                                              input logic stall);
        fetch_act_t act;
        act = ACT_ADVANCE;
        if (redirect) begin
            act = ACT_REDIRECT;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end
        return act;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program counter, incrementer and the redirect/stall mux
// that chooses which address goes out to instruction memory this cycle.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                PC_INC   = DEF_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [ADDR_W-1:0] rq_pc,
    output logic [ADDR_W-1:0] issue_addr
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    fetch_act_t        act;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;

    assign act = decode_act(redirect, flush, stall);

    // Pick the issued address and the following PC; a stall re-reads the in-flight word.
    always_comb begin
        issue_addr = pc_q;
        pc_next    = pc_q + INC;
        case (act)
            ACT_REDIRECT: begin
                issue_addr = redirect_pc;
                pc_next    = redirect_pc + INC;
            end
            ACT_STALL: begin
                issue_addr = rq_pc;
                pc_next    = pc_q;
            end
            default: begin
            end
        endcase
    end

    // PC register; wraps silently modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with stall, flush and branch redirect.
// Tracks the one outstanding synchronous imem read and owns the IF/ID register.
// Optional build macro FETCH_STAT_EN adds fetch_cnt_o, a saturating count of
// cycles in which IF/ID loads a live instruction.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter int                PC_INC   = DEF_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [INST_W-1:0] ifid_inst_o,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic              ifid_valid_o
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]       fetch_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    // Same layout as fetch_pkg::ifid_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } ifid_reg_t;

    fetch_act_t        act;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rq_pc_q;
    logic              rq_valid_q;
    ifid_reg_t         ifid_q;

    assign act = decode_act(redirect_i, flush_i, stall_i);

    fetch_pc_gen #(
        .ADDR_W   (ADDR_W),
        .PC_INC   (PC_INC),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall_i),
        .flush       (flush_i),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .rq_pc       (rq_pc_q),
        .issue_addr  (issue_addr)
    );

    assign imem_addr_o = issue_addr;

    // Remember the address issued this cycle; a flush issues but marks the read dead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq_pc_q    <= '0;
            rq_valid_q <= 1'b0;
        end else begin
            case (act)
                ACT_ADVANCE, ACT_REDIRECT: begin
                    rq_pc_q    <= issue_addr;
                    rq_valid_q <= 1'b1;
                end
                ACT_FLUSH: begin
                    rq_pc_q    <= issue_addr;
                    rq_valid_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // IF/ID captures the word returned for last cycle's request, or a NOP bubble on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_q.inst  <= NOP_INST;
            ifid_q.pc    <= '0;
            ifid_q.valid <= 1'b0;
        end else begin
            case (act)
                ACT_ADVANCE: begin
                    ifid_q.inst  <= imem_data_i;
                    ifid_q.pc    <= rq_pc_q + INC;
                    ifid_q.valid <= rq_valid_q;
                end
                ACT_FLUSH, ACT_REDIRECT: begin
                    ifid_q.inst  <= NOP_INST;
                    ifid_q.pc    <= '0;
                    ifid_q.valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ifid_inst_o  = ifid_q.inst;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_valid_o = ifid_q.valid;

`ifdef FETCH_STAT_EN
    logic [31:0] fetch_cnt_q;

    // Count live IF/ID loads, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
        end else if (act == ACT_ADVANCE && rq_valid_q && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
`else
    // Statistics disabled: no counter state exists in this build.
`endif

endmodule
